// File: rtl/uart_receiver.sv
// UART 8-bit receiver, 16x oversampled, with sticky overrun/frame/parity flags.
// Define UART_RX_PARITY_EN to expect an even-parity bit after bit 7.
module uart_receiver #(
  parameter int OSR_DIV = 651
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic       UART_RX,
  input  logic       rx_ack,
  input  logic       err_clr,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       overrun,
  output logic       frame_err,
  output logic       parity_err
);

  localparam int DW = (OSR_DIV > 1) ? $clog2(OSR_DIV) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PAR   = 3'd3;
`endif
  localparam logic [2:0] S_STOP  = 3'd4;

  logic          r_sync1;
  logic          r_sync2;
  logic          r_rx_d;
  logic [2:0]    r_state;
  logic [DW-1:0] r_div;
  logic [3:0]    r_tick_cnt;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;

  logic w_fall;
  logic w_tick;
  logic w_mid;
  logic w_end;
  logic w_stop_smp;
  logic w_frame_ev;
  logic w_deliver;
  logic w_par_ev;
  logic w_par_bad;

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_rx_d  <= 1'b1;
    end else begin
      r_sync1 <= UART_RX;
      r_sync2 <= r_sync1;
      r_rx_d  <= r_sync2;
    end
  end

  // Edge-based start: a line stuck low never re-arms until it goes high.
  assign w_fall = r_rx_d & ~r_sync2;

  assign w_tick = (r_state != S_IDLE) &&
                  (r_div == DW'(OSR_DIV - 1));
  assign w_mid  = w_tick && (r_tick_cnt == 4'd7);
  assign w_end  = w_tick && (r_tick_cnt == 4'd15);

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_div <= '0;
    end else if (r_state == S_IDLE || w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DW'(1);
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_tick_cnt <= 4'd0;
      r_bit_cnt  <= 3'd0;
      r_shift    <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tick_cnt <= 4'd0;
          r_bit_cnt  <= 3'd0;
          if (w_fall) begin
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_mid) begin
            r_tick_cnt <= 4'd0;
            r_state    <= r_sync2 ? S_IDLE : S_DATA;
          end else if (w_tick) begin
            r_tick_cnt <= r_tick_cnt + 4'd1;
          end
        end
        S_DATA: begin
          if (w_tick) begin
            r_tick_cnt <= r_tick_cnt + 4'd1;
          end
          if (w_end) begin
            r_shift   <= {r_sync2, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              r_state <= S_PAR;
`else
              r_state <= S_STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PAR: begin
          if (w_tick) begin
            r_tick_cnt <= r_tick_cnt + 4'd1;
          end
          if (w_end) begin
            r_state <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (w_tick) begin
            r_tick_cnt <= r_tick_cnt + 4'd1;
          end
          if (w_end) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef UART_RX_PARITY_EN
  logic r_par_bad;

  assign w_par_ev = (r_state == S_PAR) && w_end &&
                    (^{r_shift, r_sync2});

  // Remembered so the stop bit is still checked after a parity miss.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_par_bad <= 1'b0;
    end else if (r_state == S_IDLE) begin
      r_par_bad <= 1'b0;
    end else if (w_par_ev) begin
      r_par_bad <= 1'b1;
    end
  end

  assign w_par_bad = r_par_bad;
`else
  assign w_par_ev  = 1'b0;
  assign w_par_bad = 1'b0;
`endif

  assign w_stop_smp = (r_state == S_STOP) && w_end;
  assign w_frame_ev = w_stop_smp && !r_sync2;
  assign w_deliver  = w_stop_smp && r_sync2 && !w_par_bad;

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
    end else if (w_deliver && (!rx_valid || rx_ack)) begin
      rx_data  <= r_shift;
      rx_valid <= 1'b1;
    end else if (rx_ack) begin
      rx_valid <= 1'b0;
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (w_deliver && rx_valid && !rx_ack) begin
        overrun <= 1'b1;
      end else if (err_clr) begin
        overrun <= 1'b0;
      end
      if (w_frame_ev) begin
        frame_err <= 1'b1;
      end else if (err_clr) begin
        frame_err <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      parity_err <= 1'b0;
    end else if (w_par_ev) begin
      parity_err <= 1'b1;
    end else if (err_clr) begin
      parity_err <= 1'b0;
    end
  end
`else
  assign parity_err = w_par_ev;
`endif

  assign rx_busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: directed frames plus random traffic
// checked against a frame-level behavioural model.
module tb_uart_receiver;

  localparam int BITC = 64;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       sys_clk = 1'b0;
  logic       reset;
  logic       UART_RX;
  logic       rx_ack;
  logic       err_clr;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       overrun;
  logic       frame_err;
  logic       parity_err;

  int total = 0;
  int bad   = 0;

  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ovr;
  logic       m_fe;
  logic       m_pe;

  uart_receiver #(.OSR_DIV(4)) dut (
    .sys_clk   (sys_clk),
    .reset     (reset),
    .UART_RX   (UART_RX),
    .rx_ack    (rx_ack),
    .err_clr   (err_clr),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_busy   (rx_busy),
    .overrun   (overrun),
    .frame_err (frame_err),
    .parity_err(parity_err)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = 8'h00;
    m_ovr   = 1'b0;
    m_fe    = 1'b0;
    m_pe    = 1'b0;
  endtask

  task automatic model_frame(input logic [7:0] b,
                             input logic stop,
                             input logic pbad);
    if (pbad) m_pe = 1'b1;
    if (!stop) begin
      m_fe = 1'b1;
    end else if (!pbad) begin
      if (m_valid) begin
        m_ovr = 1'b1;
      end else begin
        m_valid = 1'b1;
        m_data  = b;
      end
    end
  endtask

  task automatic drive_bit(input logic v, input int n);
    UART_RX = v;
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic idle(input int n);
    drive_bit(1'b1, n);
  endtask

  task automatic send_frame(input logic [7:0] b,
                            input logic stop,
                            input logic pbad);
    drive_bit(1'b0, BITC);
    for (int i = 0; i < 8; i++) drive_bit(b[i], BITC);
    if (PAR_EN) drive_bit(^b ^ pbad, BITC);
    drive_bit(stop, BITC);
    model_frame(b, stop, PAR_EN && pbad);
  endtask

  task automatic ack();
    rx_ack = 1'b1;
    @(negedge sys_clk);
    rx_ack = 1'b0;
    m_valid = 1'b0;
  endtask

  task automatic clr();
    err_clr = 1'b1;
    @(negedge sys_clk);
    err_clr = 1'b0;
    m_ovr = 1'b0;
    m_fe  = 1'b0;
    m_pe  = 1'b0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, rx_valid, m_valid);
    chk({tag, ".data"}, rx_data, m_data);
    chk({tag, ".ovr"}, overrun, m_ovr);
    chk({tag, ".fe"}, frame_err, m_fe);
    chk({tag, ".pe"}, parity_err, m_pe);
    chk({tag, ".busy"}, rx_busy, 1'b0);
  endtask

  initial begin
    int lat;
    reset   = 1'b1;
    UART_RX = 1'b1;
    rx_ack  = 1'b0;
    err_clr = 1'b0;
    model_reset();
    repeat (3) @(negedge sys_clk);
    check_all("rst");
    reset = 1'b0;
    idle(10);

    // single frame, plus stop-sample to rx_valid latency
    lat = -1;
    fork
      send_frame(8'h55, 1'b1, 1'b0);
      begin
        int c;
        for (c = 0; c < 900 && !rx_valid; c++) @(negedge sys_clk);
        lat = c;
      end
    join
    chk("lat55", (lat >= 608 + (PAR_EN ? 64 : 0)) &&
                 (lat <= 614 + (PAR_EN ? 64 : 0)), 1'b1);
    idle(8);
    check_all("f55");
    chk("f55.byte", rx_data, 8'h55);
    ack();
    idle(4);
    chk("ack55", rx_valid, 1'b0);
    ack();
    chk("ack_idle", rx_valid, 1'b0);

    // start glitch
    UART_RX = 1'b0;
    repeat (20) @(negedge sys_clk);
    UART_RX = 1'b1;
    repeat (5) @(negedge sys_clk);
    chk("glitch.busy_in", rx_busy, 1'b1);
    idle(40);
    check_all("glitch");

    // overrun
    send_frame(8'hA3, 1'b1, 1'b0);
    send_frame(8'h0F, 1'b1, 1'b0);
    idle(8);
    check_all("ovr");
    chk("ovr.byte", rx_data, 8'hA3);
    chk("ovr.flag", overrun, 1'b1);
    clr();
    check_all("ovr_clr");
    ack();

    // frame error with line stuck low afterwards
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (150) @(negedge sys_clk);
    chk("stuck.busy", rx_busy, 1'b0);
    check_all("fe");
    chk("fe.flag", frame_err, 1'b1);
    idle(20);
    send_frame(8'h81, 1'b1, 1'b0);
    idle(8);
    check_all("f81");
    chk("f81.byte", rx_data, 8'h81);
    clr();
    ack();

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1);
    idle(8);
    check_all("pbad");
    chk("pbad.flag", parity_err, 1'b1);
    send_frame(8'h07, 1'b1, 1'b0);
    idle(8);
    check_all("pok");
    chk("pok.byte", rx_data, 8'h07);
    clr();
    ack();
`endif

    // reset in the middle of bit 4 of 0xFF
    send_frame(8'h66, 1'b1, 1'b0);
    idle(8);
    drive_bit(1'b0, BITC);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, BITC);
    drive_bit(1'b1, BITC / 2);
    reset = 1'b1;
    model_reset();
    repeat (3) @(negedge sys_clk);
    check_all("midrst");
    reset = 1'b0;
    idle(200);
    check_all("postrst");
    send_frame(8'h12, 1'b1, 1'b0);
    idle(8);
    check_all("f12");
    chk("f12.byte", rx_data, 8'h12);
    ack();

    // random traffic
    for (int n = 0; n < 24; n++) begin
      logic [7:0] b;
      logic       st;
      logic       pb;
      b  = 8'($urandom_range(0, 255));
      st = ($urandom_range(0, 5) != 0);
      pb = PAR_EN && ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 1) == 1) ack();
      if ($urandom_range(0, 4) == 0) clr();
      send_frame(b, st, pb);
      idle(4 + $urandom_range(0, 30));
      check_all($sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
